// File: rtl/pe_part_sum_rx.sv
// Receive-side partial-sum reducer: accumulates per-rank flits from NUM_SRC PEs, then drains
// the sums into the activation regfile. Define PART_SUM_SAT_EN for saturating accumulation.
module pe_part_sum_rx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RANK_MAX   = 64,
  parameter int unsigned RANK_WIDTH = 7,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned NUM_SRC    = 16,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_rx,
  input  logic [RANK_WIDTH-1:0] rank_no,
  output logic                  rx_rdy,
  input  logic                  part_sum_recv_en,
  input  logic [IDX_WIDTH-1:0]  part_sum_recv_idx,
  input  logic [DATA_WIDTH-1:0] part_sum_recv_data,
  output logic                  act_write_en,
  output logic [IDX_WIDTH-1:0]  act_write_addr,
  output logic [DATA_WIDTH-1:0] act_write_data,
  output logic                  fin_rx,
  output logic                  rx_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [RANK_WIDTH-1:0] rank_q, rank_d;
  logic [CNT_WIDTH-1:0]  expected_q, expected_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [IDX_WIDTH-1:0]  drain_addr_q, drain_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [IDX_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  fin_q, fin_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] acc_q [RANK_MAX];
  logic                  acc_clr;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic                  accept;
  logic                  idx_in_range;
  logic                  drain_last;
  logic [RANK_WIDTH-1:0] rank_clamped;

  assign rx_rdy         = (state_q == RECV);
  assign accept         = part_sum_recv_en && rx_rdy;
  assign idx_in_range   = RANK_WIDTH'(part_sum_recv_idx) < rank_q;
  assign drain_last     = drain_addr_q == IDX_WIDTH'(rank_q - RANK_WIDTH'(1));
  assign rank_clamped   = (rank_no > RANK_WIDTH'(RANK_MAX)) ? RANK_WIDTH'(RANK_MAX) : rank_no;
  assign acc_rd         = acc_q[part_sum_recv_idx];

  assign act_write_en   = wr_en_q;
  assign act_write_addr = wr_addr_q;
  assign act_write_data = wr_data_q;
  assign fin_rx         = fin_q;
  assign rx_err         = err_q;
  assign busy           = busy_q;

`ifdef PART_SUM_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH:0] acc_wide;

  // Sign-extended add; differing top two bits flag signed overflow.
  always_comb begin
    acc_wide = {acc_rd[DATA_WIDTH-1], acc_rd}
             + {part_sum_recv_data[DATA_WIDTH-1], part_sum_recv_data};
    acc_sum  = acc_wide[DATA_WIDTH-1:0];
    if (acc_wide[DATA_WIDTH] != acc_wide[DATA_WIDTH-1]) begin
      acc_sum = acc_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign acc_sum = acc_rd + part_sum_recv_data;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    expected_d   = expected_q;
    count_d      = count_q;
    drain_addr_d = drain_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    fin_d        = 1'b0;
    err_d        = 1'b0;
    acc_clr      = 1'b0;
    acc_we       = 1'b0;

    if (start_rx && (state_q != IDLE))         err_d = 1'b1;
    if (part_sum_recv_en && (state_q != RECV)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_rx) begin
          if (rank_no > RANK_WIDTH'(RANK_MAX)) err_d = 1'b1;
          if (rank_no == '0) begin
            state_d = DONE;
          end else begin
            rank_d       = rank_clamped;
            expected_d   = CNT_WIDTH'(rank_clamped) * CNT_WIDTH'(NUM_SRC);
            count_d      = '0;
            drain_addr_d = '0;
            acc_clr      = 1'b1;
            state_d      = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          count_d = count_q + CNT_WIDTH'(1);
          if (idx_in_range) acc_we = 1'b1;
          else              err_d  = 1'b1;
          if (count_d == expected_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        wr_en_d      = 1'b1;
        wr_addr_d    = drain_addr_q;
        wr_data_d    = acc_q[drain_addr_q];
        drain_addr_d = drain_addr_q + IDX_WIDTH'(1);
        if (drain_last) state_d = DONE;
      end
      DONE: begin
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rank_q       <= '0;
      expected_q   <= '0;
      count_q      <= '0;
      drain_addr_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      expected_q   <= expected_d;
      count_q      <= count_d;
      drain_addr_q <= drain_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      fin_q        <= fin_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  // Accumulator array: single-cycle read-modify-write keeps repeated indices hazard-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RANK_MAX; i++) acc_q[i] <= '0;
    end else if (acc_clr) begin
      for (int unsigned i = 0; i < RANK_MAX; i++) acc_q[i] <= '0;
    end else if (acc_we) begin
      acc_q[part_sum_recv_idx] <= acc_sum;
    end
  end

endmodule
